stack_unit: RTL and testbench
=============================

Name: stack_unit

Overview:
- Operand stack that services the multicycle stack-machine controller's push / pop / tos commands.
- Holds the data pushed from the MtoS mux (ALU result or memory data) and returns the top of stack through a registered output.
- That output feeds the A/B operand registers and the memory write-data path.
- Responder side of the controller's stack command interface; also reports occupancy and sticky overflow/underflow errors.

Parameters:
- WIDTH, 8, data word width (matches the 8-bit datapath).
- DEPTH, 8, number of stack entries; must be a power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock shared with the controller.
- rst  input  1  asynchronous, active-high reset.
- push  input  1  write din to the new top this cycle.
- pop  input  1  remove the top and present it on dout.
- tos  input  1  present the top on dout without removing it.
- din  input  WIDTH  data to push.
- clr_err  input  1  synchronous clear of ovf/unf.
- dout  output  WIDTH  registered top-of-stack read data.
- empty  output  1  sp == 0.
- full  output  1  sp == DEPTH.
- count  output  PTR_W+1  current occupancy (sp).
- ovf  output  1  sticky: a push was attempted while full.
- unf  output  1  sticky: a pop or tos was attempted while empty.

Behaviour:
- Reset (async, immediate, also mid-operation): sp=0, dout=0, ovf=0, unf=0. Storage contents are not reset and are undefined until written. empty=1, full=0, count=0.
- State is sp (0..DEPTH) plus storage. Commands are sampled on the rising edge. empty, full and count are combinational from sp.
- push only, not full: mem[sp] <= din; sp <= sp+1; dout unchanged.
- pop only, not empty: dout <= mem[sp-1]; sp <= sp-1.
- tos only, not empty: dout <= mem[sp-1]; sp unchanged.
- Latency: dout is valid from the edge that samples pop/tos, i.e. during the controller's following state (ldA/ldB/memWrite state). It holds until the next successful pop or tos.
- push+pop, not empty: replace-top. dout <= old mem[sp-1]; mem[sp-1] <= din; sp unchanged. This is legal even when full (no ovf).
- push+pop on empty: unf <= 1; the push executes (mem[0] <= din, sp <= 1); dout unchanged.
- pop+tos: pop dominates; tos is ignored.
- push+tos, not empty: dout <= old top (mem[sp-1]); the push executes normally (ovf rules apply).
- push on full (without pop): ignored, ovf <= 1, storage and sp unchanged.
- pop or tos on empty (without push): ignored, unf <= 1, dout unchanged.
- clr_err clears ovf and unf. A new error in the same cycle wins (flag stays/becomes 1).
- No command: nothing changes.
- sp never wraps. It saturates at the bounds via the ignore rules above.

Decomposition:
- Package stack_pkg:
  - default STACK_WIDTH=8 and STACK_DEPTH=8 constants;
  - typedef stack_word_t = logic [STACK_WIDTH-1:0];
  - 3-bit command typedef/constants {push,pop,tos} shared with the controller.
- Sub-module stack_regfile:
  - DEPTH x WIDTH storage;
  - one synchronous write port (we, waddr, wdata);
  - one combinational read port (raddr, rdata).
- stack_unit keeps sp, the command decode, the dout register and the error flags.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles -> count=3, empty=0, dout=0x00; next pop -> dout=0x33 next cycle, count=2; then tos -> dout=0x22, count stays 2.
- Push 8 values 0x01..0x08 (DEPTH=8) -> full=1; push 0x99 -> ovf=1, count=8; then pop -> dout=0x08 (0x99 not stored).
- From empty, pop -> unf=1, dout unchanged, count=0; clr_err together with another pop -> unf stays 1; clr_err alone -> unf=0.
- Stack [0x05, 0x07], push+pop with din=0x0C -> dout=0x07, count=2; next tos -> dout=0x0C.
- Controller-style sequence, pop/wait/pop/wait/push(din=0x12) on stack [0x03, 0x0F] -> dout=0x0F during the cycle after the first pop, 0x03 after the second, final count=1, tos -> 0x12.
- Assert rst asynchronously mid-cycle with count=4 -> count=0, dout=0, ovf=unf=0 before the next clock edge; a subsequent pop -> unf=1.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared operand-stack types: default geometry and the {push,pop,tos} command vector.
package stack_pkg;

  localparam int STACK_WIDTH = 8;
  localparam int STACK_DEPTH = 8;

  typedef logic [STACK_WIDTH-1:0] stack_word_t;

  // Command vector as driven by the controller, MSB first: {push, pop, tos}.
  typedef logic [2:0] stack_cmd_t;

  localparam int CMD_PUSH = 2;
  localparam int CMD_POP  = 1;
  localparam int CMD_TOS  = 0;

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: one synchronous write port, one combinational read port, no reset.
module stack_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// Operand stack for the stack-machine controller: push/pop/tos decode, registered
// top-of-stack output, occupancy and sticky overflow/underflow flags.
module stack_unit
  import stack_pkg::*;
#(
  parameter int WIDTH   = STACK_WIDTH,
  parameter int DEPTH   = STACK_DEPTH,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             tos,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count,
  output logic             ovf,
  output logic             unf
);

  localparam logic [PTR_W:0] SP_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] SP_MAX = (PTR_W+1)'(DEPTH);

  stack_cmd_t       cmd;
  logic [PTR_W:0]   sp, sp_nxt, sp_inc, sp_dec;
  logic [PTR_W-1:0] top_addr, waddr;
  logic [WIDTH-1:0] rdata;
  logic             we, ld_dout, set_ovf, set_unf;

  assign cmd      = {push, pop, tos};
  assign sp_inc   = sp + SP_ONE;
  assign sp_dec   = sp - SP_ONE;
  assign top_addr = sp_dec[PTR_W-1:0];

  assign empty = (sp == '0);
  assign full  = (sp == SP_MAX);
  assign count = sp;

  // Pop dominates tos; a push paired with pop on a non-empty stack replaces the top.
  always_comb begin
    we      = 1'b0;
    waddr   = sp[PTR_W-1:0];
    sp_nxt  = sp;
    ld_dout = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (cmd[CMD_POP]) begin
      if (empty) begin
        set_unf = 1'b1;
        if (cmd[CMD_PUSH]) begin
          we     = 1'b1;
          sp_nxt = sp_inc;
        end
      end else if (cmd[CMD_PUSH]) begin
        ld_dout = 1'b1;
        we      = 1'b1;
        waddr   = top_addr;
      end else begin
        ld_dout = 1'b1;
        sp_nxt  = sp_dec;
      end
    end else begin
      if (cmd[CMD_TOS]) begin
        if (empty) set_unf = 1'b1;
        else       ld_dout = 1'b1;
      end
      if (cmd[CMD_PUSH]) begin
        if (full) begin
          set_ovf = 1'b1;
        end else begin
          we     = 1'b1;
          sp_nxt = sp_inc;
        end
      end
    end
  end

  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (din),
    .raddr (top_addr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp   <= '0;
      dout <= '0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else begin
      sp  <= sp_nxt;
      ovf <= set_ovf | (ovf & ~clr_err);
      unf <= set_unf | (unf & ~clr_err);
      if (ld_dout) dout <= rdata;
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: directed scenarios plus random commands
// against a queue-based reference model.
module tb_stack_unit;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0, pop = 1'b0, tos = 1'b0, clr_err = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       empty, full, ovf, unf;
  logic [3:0] count;

  stack_unit dut (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .tos     (tos),
    .din     (din),
    .clr_err (clr_err),
    .dout    (dout),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .ovf     (ovf),
    .unf     (unf)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // Reference model: queue with the top at the back.
  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_ovf, m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = 8'h00;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic model_step(input bit p, input bit o, input bit t, input logic [7:0] d, input bit c);
    bit e_ovf = 1'b0;
    bit e_unf = 1'b0;
    if (o) begin
      if (q.size() == 0) begin
        e_unf = 1'b1;
        if (p) q.push_back(d);
      end else if (p) begin
        m_dout = q[q.size()-1];
        q[q.size()-1] = d;
      end else begin
        m_dout = q.pop_back();
      end
    end else begin
      if (t) begin
        if (q.size() == 0) e_unf = 1'b1;
        else m_dout = q[q.size()-1];
      end
      if (p) begin
        if (q.size() == DEPTH) e_ovf = 1'b1;
        else q.push_back(d);
      end
    end
    m_ovf = e_ovf | (m_ovf & ~c);
    m_unf = e_unf | (m_unf & ~c);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(q.size() == DEPTH));
    chk({tag, ".dout"},  32'(dout),  32'(m_dout));
    chk({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
    chk({tag, ".unf"},   32'(unf),   32'(m_unf));
  endtask

  // Called at a negedge; drives one command across the next rising edge, checks at the following negedge.
  task automatic step(input string tag, input bit p, input bit o, input bit t,
                      input logic [7:0] d, input bit c);
    push = p; pop = o; tos = t; din = d; clr_err = c;
    @(posedge clk);
    model_step(p, o, t, d, c);
    @(negedge clk);
    push = 1'b0; pop = 1'b0; tos = 1'b0; clr_err = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all("reset");
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Three pushes, pop, tos
    step("p11", 1, 0, 0, 8'h11, 0);
    step("p22", 1, 0, 0, 8'h22, 0);
    step("p33", 1, 0, 0, 8'h33, 0);
    chk("push3.dout", 32'(dout), 32'h00);
    chk("push3.count", 32'(count), 32'd3);
    step("pop1", 0, 1, 0, 8'h00, 0);
    chk("pop1.dout", 32'(dout), 32'h33);
    step("tos1", 0, 0, 1, 8'h00, 0);
    chk("tos1.dout", 32'(dout), 32'h22);
    chk("tos1.count", 32'(count), 32'd2);

    // Fill, overflow, pop
    do_reset();
    for (int i = 1; i <= DEPTH; i++) step("fill", 1, 0, 0, 8'(i), 0);
    chk("fill.full", 32'(full), 32'd1);
    step("ovfpush", 1, 0, 0, 8'h99, 0);
    chk("ovf.flag", 32'(ovf), 32'd1);
    chk("ovf.count", 32'(count), 32'd8);
    step("replfull", 1, 1, 0, 8'hA5, 0);
    chk("replfull.dout", 32'(dout), 32'h08);
    step("popfull", 0, 1, 0, 8'h00, 0);
    chk("popfull.dout", 32'(dout), 32'hA5);

    // Underflow and clr_err priority
    do_reset();
    step("unf1", 0, 1, 0, 8'h00, 0);
    chk("unf1.flag", 32'(unf), 32'd1);
    step("unfclr", 0, 1, 0, 8'h00, 1);
    chk("unfclr.flag", 32'(unf), 32'd1);
    step("clr", 0, 0, 0, 8'h00, 1);
    chk("clr.flag", 32'(unf), 32'd0);
    step("pushpop_empty", 1, 1, 0, 8'h44, 0);
    chk("ppe.count", 32'(count), 32'd1);
    step("pushtos", 1, 0, 1, 8'h55, 0);
    chk("pushtos.dout", 32'(dout), 32'h44);

    // Replace-top
    do_reset();
    step("p05", 1, 0, 0, 8'h05, 0);
    step("p07", 1, 0, 0, 8'h07, 0);
    step("repl", 1, 1, 0, 8'h0C, 0);
    chk("repl.dout", 32'(dout), 32'h07);
    step("repltos", 0, 0, 1, 8'h00, 0);
    chk("repltos.dout", 32'(dout), 32'h0C);

    // Controller-style pop/wait/pop/wait/push
    do_reset();
    step("p03", 1, 0, 0, 8'h03, 0);
    step("p0f", 1, 0, 0, 8'h0F, 0);
    step("cpop1", 0, 1, 1, 8'h00, 0);
    chk("cpop1.dout", 32'(dout), 32'h0F);
    step("cwait1", 0, 0, 0, 8'h00, 0);
    step("cpop2", 0, 1, 0, 8'h00, 0);
    chk("cpop2.dout", 32'(dout), 32'h03);
    step("cwait2", 0, 0, 0, 8'h00, 0);
    step("cpush", 1, 0, 0, 8'h12, 0);
    chk("cpush.count", 32'(count), 32'd1);
    step("ctos", 0, 0, 1, 8'h00, 0);
    chk("ctos.dout", 32'(dout), 32'h12);

    // Asynchronous reset mid-cycle
    do_reset();
    for (int i = 0; i < 4; i++) step("pre", 1, 0, 0, 8'hC0 + 8'(i), 0);
    step("preov", 0, 0, 1, 8'h00, 0);
    step("preunf", 0, 0, 0, 8'h00, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst.count", 32'(count), 32'd0);
    chk("arst.dout", 32'(dout), 32'h00);
    chk("arst.ovf", 32'(ovf), 32'd0);
    chk("arst.unf", 32'(unf), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    step("arst_pop", 0, 1, 0, 8'h00, 0);
    chk("arst_pop.unf", 32'(unf), 32'd1);

    // Random commands, push-heavy first half then pop-heavy
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int pw = (n < 300) ? 60 : 35;
      bit p = ($urandom_range(0, 99) < pw);
      bit o = ($urandom_range(0, 99) < 35);
      bit t = ($urandom_range(0, 99) < 25);
      bit c = ($urandom_range(0, 99) < 6);
      step("rand", p, o, t, 8'($urandom_range(0, 255)), c);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
